anubis_enc_round_ctrl: RTL
==========================

Name: anubis_enc_round_ctrl

Overview:
Iterative Anubis-128 encryption core controller. It accepts one 128-bit plaintext block and sequences it through the round datapath once per cycle. The datapath chain is Gamma (S-box), Tau (byte transpose), Theta (MDS) and Sigma (round-key XOR). Round keys come from the external key-schedule block over a request/valid handshake, and the ciphertext leaves on a valid/ready output port. The block sits between the host block interface and the shared combinational Gamma/Tau/Theta modules.

Parameters:
ROUNDS, 12, number of keyed rounds R (8+N, N=4 for 128-bit key); final round omits Theta
RK_IDX_W, 4, width of round-key index; must satisfy 2**RK_IDX_W > ROUNDS

Ports:
clk  in  1  single system clock, rising edge
reset_n  in  1  asynchronous active-low reset
in_valid  in  1  plaintext block offered
in_ready  out  1  block can accept plaintext (high only in IDLE)
in_data  in  128  plaintext, byte 0 at [127:120], row-major 4x4
rk_req  out  1  round key requested
rk_idx  out  RK_IDX_W  index of requested round key, 0..ROUNDS
rk_valid  in  1  rk_data holds key rk_idx this cycle
rk_data  in  128  round key K[rk_idx]
out_valid  out  1  ciphertext available
out_ready  in  1  downstream accepts ciphertext
out_data  out  128  ciphertext (state register)
busy  out  1  high in any state except IDLE

Behaviour:
- Reset (async, reset_n=0): FSM=IDLE, state register=0, round counter=0. Outputs: in_ready=1, rk_req=0, rk_idx=0, out_valid=0, out_data=0, busy=0. Reset mid-operation abandons the block; no partial output.
- FSM states: IDLE, KEY0, ROUND, DONE.
- IDLE: in_ready=1. On in_valid&in_ready edge: state<=in_data, cnt<=0, go KEY0. in_valid in any other state is ignored (in_ready=0).
- KEY0: rk_req=1, rk_idx=0. On rk_valid: state<=state^rk_data, cnt<=1, go ROUND. No rk_valid: hold.
- ROUND: rk_req=1, rk_idx=cnt. On rk_valid: state<=Sigma(Theta(Tau(Gamma(state))),rk_data), with Theta bypassed when cnt==ROUNDS. If cnt==ROUNDS go DONE, else cnt<=cnt+1. No rk_valid: state, cnt and rk_idx hold.
- rk_idx and rk_req are registered-state decodes, stable while waiting. A key is consumed only on rk_req&rk_valid; rk_valid while rk_req=0 is ignored.
- DONE: out_valid=1, out_data=state, stable until out_ready. On out_valid&out_ready: go IDLE, out_valid=0. No output bypass; the next block is accepted at the earliest one cycle after the output handshake.
- Latency with rk_valid tied high: accept edge T → out_valid high after edge T+ROUNDS+1, i.e. first observable in cycle T+ROUNDS+2 (14 cycles for ROUNDS=12). Each rk_valid-low cycle adds exactly 1 cycle.
- Exactly ROUNDS+1 keys are consumed per block, indices 0,1,...,ROUNDS in order, no repeats.
- Round counter width RK_IDX_W; it never wraps because the terminal compare is at ROUNDS.

Decomposition:
- Package anubis_pkg holds:
  - ANUBIS_ROUNDS_128=12
  - BLOCK_W=128
  - the FSM state enum (IDLE, KEY0, ROUND, DONE)
  - the 128-bit block typedef
- Sub-module anubis_round_fn: purely combinational Gamma→Tau→Theta(bypass when last=1)→XOR key. It instantiates the existing Gamma, Tau and Theta modules. Ports: state_in, rk, last, state_out.
- The controller contains only the FSM, counter, state register and handshakes.

Test Plan:
1. Reset: assert reset_n=0 mid-cycle → in_ready=1, busy=0, out_valid=0, rk_req=0, out_data=0 immediately; no clock required.
2. in_data=0, all keys K[i]=0, rk_valid tied 1 → rk_idx sequence 0..12 on consecutive cycles, out_valid in 14th cycle after accept; out_data equals the golden C model; exactly 13 keys consumed.
3. Keys K[i]={16{i[7:0]}}, rk_valid low 3 cycles while rk_idx=5 → state and rk_idx hold at 5; out_valid 3 cycles later (17th cycle); ciphertext matches the model.
4. out_ready low 4 cycles in DONE → out_data stable and in_ready=0 throughout. Output handshake, then in_valid high → new block accepted on the next cycle.
5. in_valid pulsed with different data during ROUND → ignored; result matches the first block only.
6. reset_n pulsed low while rk_idx=7 → all outputs return to reset values. Next block from idx 0 produces the correct model ciphertext.

Source files
------------

// File: rtl/anubis_pkg.sv
// Shared definitions for the Anubis-128 encryption slice.
//   ANUBIS_ROUNDS_128 : keyed rounds for a 128-bit key (8 + N, N = 4)
//   BLOCK_W           : cipher block width
//   fsm_t             : round controller states
//   block_t           : 128-bit state / key word, byte 0 at [127:120], row-major 4x4
//   gf_xtime          : multiply by x in GF(2^8) modulo x^8+x^4+x^3+x^2+1 (0x11D)
package anubis_pkg;

    localparam int ANUBIS_ROUNDS_128 = 12;
    localparam int BLOCK_W           = 128;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        KEY0  = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } fsm_t;

    typedef logic [BLOCK_W-1:0] block_t;

    function automatic logic [7:0] gf_xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1d : 8'h00);
    endfunction

endpackage

// File: rtl/anubis_gamma.sv
// Gamma layer: applies the Anubis 8-bit S-box to all 16 state bytes.
// The S-box is the mini-box composite: P|Q layer, bit mix, Q|P layer,
// bit mix, P|Q layer, where the bit mix swaps bits 1<->4 and 3<->6.
//   din  : state in
//   dout : substituted state
module anubis_gamma
    import anubis_pkg::*;
(
    input  block_t din,
    output block_t dout
);

    localparam logic [63:0] P_TBL = 64'h3fe0_54bc_da96_7821;
    localparam logic [63:0] Q_TBL = 64'h9e56_a23c_f04d_7b18;

    // Entry 0 sits in the top nibble, so the base index is 4*(15-x).
    function automatic logic [3:0] p_box(input logic [3:0] x);
        return P_TBL[{~x, 2'b00} +: 4];
    endfunction

    function automatic logic [3:0] q_box(input logic [3:0] x);
        return Q_TBL[{~x, 2'b00} +: 4];
    endfunction

    function automatic logic [7:0] bit_mix(input logic [7:0] c);
        return (c & 8'ha5) | ((c & 8'h0a) << 3) | ((c & 8'h50) >> 3);
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] c;
        c = {p_box(x[7:4]), q_box(x[3:0])};
        c = bit_mix(c);
        c = {q_box(c[7:4]), p_box(c[3:0])};
        c = bit_mix(c);
        c = {p_box(c[7:4]), q_box(c[3:0])};
        return c;
    endfunction

    for (genvar i = 0; i < 16; i++) begin : g_byte
        assign dout[8*i +: 8] = sbox(din[8*i +: 8]);
    end

endmodule

// File: rtl/anubis_round_fn.sv
// One Anubis round, purely combinational:
//   state_out = Sigma(Theta(Tau(Gamma(state_in))), rk), Theta skipped when last=1.
//   state_in  : current cipher state
//   rk        : round key for this round
//   last      : final round (no Theta)
//   state_out : next cipher state
module anubis_round_fn
    import anubis_pkg::*;
(
    input  block_t state_in,
    input  block_t rk,
    input  logic   last,
    output block_t state_out
);

    block_t g_st;
    block_t t_st;
    block_t th_st;

    anubis_gamma u_gamma (.din(state_in), .dout(g_st));
    anubis_tau   u_tau   (.din(g_st),     .dout(t_st));
    anubis_theta u_theta (.din(t_st),     .dout(th_st));

    assign state_out = (last ? t_st : th_st) ^ rk;

endmodule

// File: rtl/anubis_tau.sv
// Tau layer: transposes the 4x4 byte matrix, out[r][c] = in[c][r].
//   din  : state in
//   dout : transposed state
module anubis_tau
    import anubis_pkg::*;
(
    input  block_t din,
    output block_t dout
);

    for (genvar r = 0; r < 4; r++) begin : g_row
        for (genvar c = 0; c < 4; c++) begin : g_col
            assign dout[8*(15-4*r-c) +: 8] = din[8*(15-4*c-r) +: 8];
        end
    end

endmodule

// File: rtl/anubis_theta.sv
// Theta layer: each row vector is multiplied by the involutory
// Hadamard matrix H = had(01, 02, 04, 06) over GF(2^8),
// H[k][j] = h[k ^ j].
//   din  : state in
//   dout : diffused state
module anubis_theta
    import anubis_pkg::*;
(
    input  block_t din,
    output block_t dout
);

    function automatic logic [31:0] theta_row(input logic [31:0] w);
        logic [7:0] a  [4];
        logic [7:0] m2 [4];
        logic [7:0] m4 [4];
        logic [7:0] m6 [4];
        for (int k = 0; k < 4; k++) begin
            a[k]  = w[8*(3-k) +: 8];
            m2[k] = gf_xtime(a[k]);
            m4[k] = gf_xtime(m2[k]);
            m6[k] = m4[k] ^ m2[k];
        end
        return {a[0]  ^ m2[1] ^ m4[2] ^ m6[3],
                m2[0] ^ a[1]  ^ m6[2] ^ m4[3],
                m4[0] ^ m6[1] ^ a[2]  ^ m2[3],
                m6[0] ^ m4[1] ^ m2[2] ^ a[3]};
    endfunction

    for (genvar r = 0; r < 4; r++) begin : g_row
        assign dout[32*(3-r) +: 32] = theta_row(din[32*(3-r) +: 32]);
    end

endmodule

// File: rtl/anubis_enc_round_ctrl.sv
// Iterative Anubis-128 encryption controller: one round per cycle,
// round keys fetched from the key schedule over rk_req/rk_valid.
//   clk, reset_n        : clock, asynchronous active-low reset
//   in_valid/in_ready   : plaintext handshake (ready only in IDLE)
//   in_data             : plaintext block
//   rk_req/rk_idx       : round key request and index 0..ROUNDS
//   rk_valid/rk_data    : round key delivery
//   out_valid/out_ready : ciphertext handshake
//   out_data            : ciphertext (the state register)
//   busy                : any state but IDLE
module anubis_enc_round_ctrl
    import anubis_pkg::*;
#(
    parameter int ROUNDS   = ANUBIS_ROUNDS_128,
    parameter int RK_IDX_W = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [BLOCK_W-1:0]  in_data,
    output logic                rk_req,
    output logic [RK_IDX_W-1:0] rk_idx,
    input  logic                rk_valid,
    input  logic [BLOCK_W-1:0]  rk_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [BLOCK_W-1:0]  out_data,
    output logic                busy
);

    localparam logic [RK_IDX_W-1:0] LAST_IDX = RK_IDX_W'(ROUNDS);

    fsm_t                fsm_p0;
    fsm_t                fsm_nxt;
    block_t              blk_p0;
    block_t              rf_out;
    logic [RK_IDX_W-1:0] cnt_p0;
    logic                last_rnd;

    // The counter stops at ROUNDS, so it never wraps.
    assign last_rnd = (cnt_p0 == LAST_IDX);

    anubis_round_fn u_round (
        .state_in  (blk_p0),
        .rk        (rk_data),
        .last      (last_rnd),
        .state_out (rf_out)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) fsm_p0 <= IDLE;
        else          fsm_p0 <= fsm_nxt;
    end

    always_comb begin
        fsm_nxt = fsm_p0;
        case (fsm_p0)
            IDLE:    if (in_valid)             fsm_nxt = KEY0;
            KEY0:    if (rk_valid)             fsm_nxt = ROUND;
            ROUND:   if (rk_valid && last_rnd) fsm_nxt = DONE;
            DONE:    if (out_ready)            fsm_nxt = IDLE;
            default:                           fsm_nxt = IDLE;
        endcase
    end

    // Pure decodes of registered state: stable while waiting on rk_valid/out_ready.
    always_comb begin
        in_ready  = 1'b0;
        rk_req    = 1'b0;
        rk_idx    = '0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (fsm_p0)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
            end
            KEY0:  rk_req = 1'b1;
            ROUND: begin
                rk_req = 1'b1;
                rk_idx = cnt_p0;
            end
            DONE:    out_valid = 1'b1;
            default: ;
        endcase
    end

    // State register / round counter: load, whitening with K0, then one round per key.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            blk_p0 <= '0;
            cnt_p0 <= '0;
        end else begin
            case (fsm_p0)
                IDLE: if (in_valid) begin
                    blk_p0 <= in_data;
                    cnt_p0 <= '0;
                end
                KEY0: if (rk_valid) begin
                    blk_p0 <= blk_p0 ^ rk_data;
                    cnt_p0 <= RK_IDX_W'(1);
                end
                ROUND: if (rk_valid) begin
                    blk_p0 <= rf_out;
                    if (!last_rnd) cnt_p0 <= cnt_p0 + RK_IDX_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign out_data = blk_p0;

endmodule
